// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoder control and ID operands, resolves the destination register, and inserts load-use bubbles.
// Latency: one cycle from id_* to ex_*. stall_out is combinational in the same cycle.
// Backpressure: ex_stall freezes every register. A load-use hazard or ex_stall raises stall_out toward PC and IF/ID. flush overrides both.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        id_pcsrc,
    input  logic              id_branch,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_alusrc1,
    input  logic              id_alusrc2,
    input  logic              id_loadbyte,
    input  logic [1:0]        id_regdst,
    input  logic [1:0]        id_memtoreg,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              flush,
    input  logic              ex_stall,
    output logic [1:0]        ex_pcsrc,
    output logic              ex_branch,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_alusrc1,
    output logic              ex_alusrc2,
    output logic              ex_loadbyte,
    output logic [1:0]        ex_memtoreg,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_shamt,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_wr_reg,
    output logic              ex_valid,
    output logic              stall_out,
    output logic [CNT_W-1:0]  bubble_count
);

    // Control bits are zeroed together on a bubble, so they travel as one bundle.
    typedef struct packed {
        logic [1:0] pcsrc;
        logic       branch;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       alusrc1;
        logic       alusrc2;
        logic       loadbyte;
        logic [1:0] memtoreg;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } data_t;

    ctrl_t             ctrl_q, ctrl_d, id_ctrl;
    data_t             data_q, data_d, id_data;
    logic [REG_AW-1:0] wr_q, wr_d, wr_next;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;

    assign id_ctrl = '{pcsrc: id_pcsrc, branch: id_branch, regwrite: id_regwrite,
                       memread: id_memread, memwrite: id_memwrite, alusrc1: id_alusrc1,
                       alusrc2: id_alusrc2, loadbyte: id_loadbyte, memtoreg: id_memtoreg};
    assign id_data = '{pc_plus4: id_pc_plus4, rs_data: id_rs_data, rt_data: id_rt_data,
                       imm: id_imm, shamt: id_shamt, rs: id_rs, rt: id_rt, rd: id_rd};

    // Destination register select; encoding 3 is unused and maps to $zero.
    always_comb begin
        wr_next = '0;
        case (id_regdst)
            2'd0:    wr_next = id_rt;
            2'd1:    wr_next = id_rd;
            2'd2:    wr_next = REG_AW'(31);
            default: wr_next = '0;
        endcase
    end

    // Load-use: a load (word or byte) in EX writing a register the ID instruction reads.
    always_comb begin
        hazard = valid_q && (ctrl_q.memread || ctrl_q.loadbyte) && (wr_q != '0) &&
                 ((id_uses_rs && (id_rs == wr_q)) || (id_uses_rt && (id_rt == wr_q)));
    end

    // Held low during reset so upstream stages are never frozen by a register being cleared.
    assign stall_out = reset & ~flush & (ex_stall | hazard);

    // Next-state selection: flush, then hold, then hazard bubble, then normal load.
    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        wr_d    = wr_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            ctrl_d  = '0;
            data_d  = id_data;
            wr_d    = '0;
            valid_d = 1'b0;
        end else if (ex_stall) begin
            // everything holds
        end else if (hazard) begin
            ctrl_d  = '0;
            data_d  = id_data;
            wr_d    = '0;
            valid_d = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            ctrl_d  = id_ctrl;
            data_d  = id_data;
            wr_d    = wr_next;
            valid_d = 1'b1;
        end
    end

    // Pipeline state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            wr_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_pcsrc     = ctrl_q.pcsrc;
    assign ex_branch    = ctrl_q.branch;
    assign ex_regwrite  = ctrl_q.regwrite;
    assign ex_memread   = ctrl_q.memread;
    assign ex_memwrite  = ctrl_q.memwrite;
    assign ex_alusrc1   = ctrl_q.alusrc1;
    assign ex_alusrc2   = ctrl_q.alusrc2;
    assign ex_loadbyte  = ctrl_q.loadbyte;
    assign ex_memtoreg  = ctrl_q.memtoreg;
    assign ex_pc_plus4  = data_q.pc_plus4;
    assign ex_rs_data   = data_q.rs_data;
    assign ex_rt_data   = data_q.rt_data;
    assign ex_imm       = data_q.imm;
    assign ex_shamt     = data_q.shamt;
    assign ex_rs        = data_q.rs;
    assign ex_rt        = data_q.rt;
    assign ex_rd        = data_q.rd;
    assign ex_wr_reg    = wr_q;
    assign ex_valid     = valid_q;
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a behavioural model.
// Bubble counter built 4 bits wide so saturation is reachable.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or before the next edge.
module tb_id_ex_stage;

    logic        clk, reset;
    logic [1:0]  id_pcsrc, id_regdst, id_memtoreg;
    logic        id_branch, id_regwrite, id_memread, id_memwrite, id_alusrc1, id_alusrc2, id_loadbyte;
    logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic        id_uses_rs, id_uses_rt, flush, ex_stall;
    logic [1:0]  ex_pcsrc, ex_memtoreg;
    logic        ex_branch, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc1, ex_alusrc2, ex_loadbyte;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_shamt, ex_rs, ex_rt, ex_rd, ex_wr_reg;
    logic        ex_valid, stall_out;
    logic [3:0]  bubble_count;

    int checks = 0;
    int fails  = 0;

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_pcsrc(id_pcsrc), .id_branch(id_branch), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_alusrc1(id_alusrc1),
        .id_alusrc2(id_alusrc2), .id_loadbyte(id_loadbyte), .id_regdst(id_regdst),
        .id_memtoreg(id_memtoreg), .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .flush(flush), .ex_stall(ex_stall),
        .ex_pcsrc(ex_pcsrc), .ex_branch(ex_branch), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_alusrc1(ex_alusrc1),
        .ex_alusrc2(ex_alusrc2), .ex_loadbyte(ex_loadbyte), .ex_memtoreg(ex_memtoreg),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_wr_reg(ex_wr_reg), .ex_valid(ex_valid), .stall_out(stall_out),
        .bubble_count(bubble_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", checks, fails);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]  pcsrc;
        logic        branch, regwrite, memread, memwrite, alusrc1, alusrc2, loadbyte;
        logic [1:0]  memtoreg;
        logic [31:0] pc4, rsd, rtd, imm;
        logic [4:0]  shamt, rs, rt, rd, wr;
        logic        valid;
    } ex_t;

    ex_t m;
    int  m_cnt;

    function automatic ex_t dut_state();
        ex_t s;
        s = '{ex_pcsrc, ex_branch, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc1,
              ex_alusrc2, ex_loadbyte, ex_memtoreg, ex_pc_plus4, ex_rs_data, ex_rt_data,
              ex_imm, ex_shamt, ex_rs, ex_rt, ex_rd, ex_wr_reg, ex_valid};
        return s;
    endfunction

    // Data fields of a bubble carry no meaning; hide them before comparing.
    function automatic ex_t visible(ex_t x);
        ex_t v = x;
        if (!v.valid) begin
            v.pc4 = '0; v.rsd = '0; v.rtd = '0; v.imm = '0;
            v.shamt = '0; v.rs = '0; v.rt = '0; v.rd = '0;
        end
        return v;
    endfunction

    function automatic ex_t id_instr();
        ex_t n;
        n.pcsrc = id_pcsrc; n.branch = id_branch; n.regwrite = id_regwrite;
        n.memread = id_memread; n.memwrite = id_memwrite; n.alusrc1 = id_alusrc1;
        n.alusrc2 = id_alusrc2; n.loadbyte = id_loadbyte; n.memtoreg = id_memtoreg;
        n.pc4 = id_pc_plus4; n.rsd = id_rs_data; n.rtd = id_rt_data; n.imm = id_imm;
        n.shamt = id_shamt; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
        if (id_regdst == 2'd0)      n.wr = id_rt;
        else if (id_regdst == 2'd1) n.wr = id_rd;
        else if (id_regdst == 2'd2) n.wr = 5'd31;
        else                        n.wr = 5'd0;
        n.valid = 1'b1;
        return n;
    endfunction

    function automatic ex_t bubble();
        ex_t b = '0;
        return b;
    endfunction

    function automatic bit model_hazard();
        bit reads_it;
        reads_it = (id_uses_rs && id_rs == m.wr) || (id_uses_rt && id_rt == m.wr);
        return m.valid && (m.memread || m.loadbyte) && (m.wr != 0) && reads_it;
    endfunction

    function automatic bit model_stall();
        return !flush && (ex_stall || model_hazard());
    endfunction

    task automatic model_reset();
        m = '0;
        m_cnt = 0;
    endtask

    // One rising edge for both DUT and model, leaving time at edge + 1.
    task automatic tick();
        bit hz;
        @(posedge clk);
        hz = model_hazard();
        if (flush)         m = bubble();
        else if (ex_stall) m = m;
        else if (hz) begin
            m = bubble();
            if (m_cnt < 15) m_cnt = m_cnt + 1;
        end else           m = id_instr();
        #1;
    endtask

    task automatic set_nop();
        id_pcsrc = 0; id_branch = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
        id_alusrc1 = 0; id_alusrc2 = 0; id_loadbyte = 0; id_regdst = 0; id_memtoreg = 0;
        id_pc_plus4 = 32'h0040_0000; id_rs_data = 32'h1111_1111; id_rt_data = 32'h2222_2222;
        id_imm = 32'h0000_0010; id_shamt = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; flush = 0; ex_stall = 0;
    endtask

    task automatic rand_inputs();
        id_pcsrc = 2'($urandom_range(0, 2)); id_branch = 1'($urandom);
        id_regwrite = 1'($urandom); id_memread = 1'($urandom); id_memwrite = 1'($urandom);
        id_alusrc1 = 1'($urandom); id_alusrc2 = 1'($urandom); id_loadbyte = 1'($urandom);
        id_regdst = 2'($urandom); id_memtoreg = 2'($urandom_range(0, 2));
        id_pc_plus4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_shamt = 5'($urandom); id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3)); id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
        flush = ($urandom_range(0, 9) == 0); ex_stall = ($urandom_range(0, 5) == 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_nop();
        ex_stall = 1'b1;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_state() !== ex_t'(0)) begin
            fails++; $display("FAIL reset_state: got %h want 0", dut_state());
        end
        checks++;
        if (bubble_count !== 4'd0 || stall_out !== 1'b0) begin
            fails++; $display("FAIL reset_cnt_stall: got cnt=%0d stall=%b want 0/0", bubble_count, stall_out);
        end
        reset = 1'b1;
        set_nop();
    endtask

    task automatic test_addu();
        set_nop();
        id_regdst = 2'd1; id_rd = 5'd5; id_rs = 5'd2; id_rt = 5'd3;
        id_uses_rs = 1; id_uses_rt = 1; id_regwrite = 1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            fails++; $display("FAIL addu_stall: got %b want 0", stall_out);
        end
        tick();
        checks++;
        if (ex_wr_reg !== 5'd5 || ex_regwrite !== 1'b1 || ex_valid !== 1'b1 || stall_out !== 1'b0) begin
            fails++; $display("FAIL addu_load: got wr=%0d rw=%b v=%b st=%b want 5/1/1/0",
                              ex_wr_reg, ex_regwrite, ex_valid, stall_out);
        end
        checks++;
        if (visible(dut_state()) !== visible(m)) begin
            fails++; $display("FAIL addu_model: got %h want %h", dut_state(), m);
        end
    endtask

    task automatic test_jal();
        set_nop();
        id_regdst = 2'd2; id_memtoreg = 2'd2; id_pcsrc = 2'd1; id_regwrite = 1;
        id_pc_plus4 = 32'h0040_0008; id_rd = 5'd7; id_rt = 5'd6;
        tick();
        checks++;
        if (ex_wr_reg !== 5'd31 || ex_memtoreg !== 2'd2 || ex_pc_plus4 !== 32'h0040_0008 || ex_pcsrc !== 2'd1) begin
            fails++; $display("FAIL jal: got wr=%0d mtr=%0d pc4=%h pcsrc=%0d want 31/2/00400008/1",
                              ex_wr_reg, ex_memtoreg, ex_pc_plus4, ex_pcsrc);
        end
    endtask

    task automatic test_load_use();
        set_nop();
        id_memread = 1; id_regdst = 2'd0; id_rt = 5'd8; id_rs = 5'd29; id_uses_rs = 1;
        id_regwrite = 1; id_memtoreg = 2'd1;
        tick();
        set_nop();
        id_rs = 5'd8; id_uses_rs = 1; id_regdst = 2'd1; id_rd = 5'd9; id_regwrite = 1;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            fails++; $display("FAIL lu_stall_on: got %b want 1", stall_out);
        end
        tick();
        checks++;
        if (visible(dut_state()) !== ex_t'(0) || bubble_count !== 4'd1) begin
            fails++; $display("FAIL lu_bubble: got %h cnt=%0d want bubble cnt=1", dut_state(), bubble_count);
        end
        checks++;
        if (stall_out !== 1'b0) begin
            fails++; $display("FAIL lu_stall_off: got %b want 0", stall_out);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_wr_reg !== 5'd9 || ex_rs !== 5'd8 || bubble_count !== 4'd1) begin
            fails++; $display("FAIL lu_reload: got v=%b wr=%0d rs=%0d cnt=%0d want 1/9/8/1",
                              ex_valid, ex_wr_reg, ex_rs, bubble_count);
        end
    endtask

    task automatic test_no_hazard();
        // load writing $zero
        set_nop();
        id_memread = 1; id_rt = 5'd0; id_regwrite = 1;
        tick();
        set_nop();
        id_rs = 5'd0; id_uses_rs = 1; id_regdst = 2'd1; id_rd = 5'd4;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            fails++; $display("FAIL nh_zero_stall: got %b want 0", stall_out);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || bubble_count !== 4'd1) begin
            fails++; $display("FAIL nh_zero_load: got v=%b cnt=%0d want 1/1", ex_valid, bubble_count);
        end
        // matching index but rs not read
        set_nop();
        id_memread = 1; id_rt = 5'd8; id_regwrite = 1;
        tick();
        set_nop();
        id_rs = 5'd8; id_rt = 5'd8; id_regdst = 2'd1; id_rd = 5'd4;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            fails++; $display("FAIL nh_unused_stall: got %b want 0", stall_out);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_wr_reg !== 5'd4) begin
            fails++; $display("FAIL nh_unused_load: got v=%b wr=%0d want 1/4", ex_valid, ex_wr_reg);
        end
        // lb in EX, read via rt
        set_nop();
        id_loadbyte = 1; id_rt = 5'd8; id_regwrite = 1;
        tick();
        set_nop();
        id_rt = 5'd8; id_uses_rt = 1; id_regdst = 2'd1; id_rd = 5'd3;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            fails++; $display("FAIL lb_stall: got %b want 1", stall_out);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || bubble_count !== 4'd2) begin
            fails++; $display("FAIL lb_bubble: got v=%b cnt=%0d want 0/2", ex_valid, bubble_count);
        end
        tick();
    endtask

    task automatic test_flush_stall();
        ex_t snap;
        set_nop();
        id_regdst = 2'd1; id_rd = 5'd12; id_regwrite = 1; id_alusrc2 = 1;
        tick();
        flush = 1; ex_stall = 1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            fails++; $display("FAIL fs_stall: got %b want 0", stall_out);
        end
        tick();
        checks++;
        if (visible(dut_state()) !== ex_t'(0) || bubble_count !== 4'd2) begin
            fails++; $display("FAIL fs_bubble: got %h cnt=%0d want bubble cnt=2", dut_state(), bubble_count);
        end
        set_nop();
        id_regdst = 2'd0; id_rt = 5'd13; id_regwrite = 1; id_memwrite = 1;
        id_imm = 32'hDEAD_0004; id_shamt = 5'd9;
        tick();
        snap = m;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            flush = 0; ex_stall = 1;
            #1;
            checks++;
            if (stall_out !== 1'b1) begin
                fails++; $display("FAIL hold_stall[%0d]: got %b want 1", i, stall_out);
            end
            tick();
            checks++;
            if (dut_state() !== snap) begin
                fails++; $display("FAIL hold_state[%0d]: got %h want %h", i, dut_state(), snap);
            end
        end
        set_nop();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            #2;
            checks++;
            if (stall_out !== model_stall()) begin
                fails++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall_out, model_stall());
            end
            tick();
            checks++;
            if (visible(dut_state()) !== visible(m) || bubble_count !== 4'(m_cnt)) begin
                fails++; $display("FAIL rand_state[%0d]: got %h cnt=%0d want %h cnt=%0d",
                                  i, dut_state(), bubble_count, m, m_cnt);
            end
        end
        set_nop();
    endtask

    task automatic test_saturation();
        set_nop();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        // A load that reads its own destination keeps re-triggering the hazard.
        id_memread = 1; id_regdst = 2'd0; id_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1; id_regwrite = 1;
        tick();
        for (int k = 1; k <= 17; k++) begin
            checks++;
            if (stall_out !== 1'b1) begin
                fails++; $display("FAIL sat_stall[%0d]: got %b want 1", k, stall_out);
            end
            tick();
            checks++;
            if (bubble_count !== 4'((k < 15) ? k : 15) || ex_valid !== 1'b0) begin
                fails++; $display("FAIL sat_cnt[%0d]: got cnt=%0d v=%b want %0d/0",
                                  k, bubble_count, ex_valid, (k < 15) ? k : 15);
            end
            tick();
        end
        checks++;
        if (bubble_count !== 4'hF) begin
            fails++; $display("FAIL sat_final: got %h want f", bubble_count);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_nop();
        id_regdst = 2'd1; id_rd = 5'd21; id_regwrite = 1; id_branch = 1;
        tick();
        ex_stall = 1;
        repeat (2) tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dut_state() !== ex_t'(0) || bubble_count !== 4'd0 || stall_out !== 1'b0) begin
            fails++; $display("FAIL async_reset: got %h cnt=%0d st=%b want all 0",
                              dut_state(), bubble_count, stall_out);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        ex_stall = 0;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_wr_reg !== 5'd21 || visible(dut_state()) !== visible(m)) begin
            fails++; $display("FAIL post_reset_load: got %h want %h", dut_state(), m);
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_addu();
        test_jal();
        test_load_use();
        test_no_hazard();
        test_flush_stall();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
